// File: rtl/acc_sequencer.sv
// acc_sequencer: accumulates signed 4-bit samples into frames of up to N
// samples using an external 4-bit adder.
// A frame closes on the N-th accept or on an early flush. The result is then
// held until the consumer takes it. Overflow either clamps the total to the
// signed rail or keeps the wrapped sum, and is recorded in a sticky flag.
module acc_sequencer #(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_ovf,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_total,
  output logic       out_ovf,
  output logic [3:0] out_count
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] total_q, total_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;

  // The adder always sees the running total and the sample on the bus;
  // only an accepted sample commits its result.
  assign add_a     = total_q;
  assign add_b     = in_data;
  assign accept    = in_valid & in_ready_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_total = total_q;
  assign out_ovf   = ovf_q;
  assign out_count = count_q;

  // Next-state logic: accumulate in ACC, hold and wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          count_d = count_q + 4'd1;
          ovf_d   = ovf_q | add_ovf;
          // Signed overflow needs both operands of the same sign, so the
          // sample's sign tells us which rail was crossed.
          if (add_ovf && SATURATE)
            total_d = in_data[3] ? 4'b1000 : 4'b0111;
          else
            total_d = add_sum;
          if (count_d == 4'(N) || flush)
            state_d = DONE;
        end else if (flush && count_q != 4'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          total_d = 4'd0;
          count_d = 4'd0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
  end

  // State and handshake registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      total_q     <= 4'd0;
      count_q     <= 4'd0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: drives a saturating and a wrapping instance with the same
// stimulus and checks both against a frame-level integer reference model.
module tb_acc_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush, out_ready;
  logic [3:0] in_data;
  logic       in_ready [2];
  logic       out_valid[2];
  logic       out_ovf  [2];
  logic       add_ovf  [2];
  logic [3:0] add_a    [2];
  logic [3:0] add_b    [2];
  logic [3:0] add_sum  [2];
  logic [3:0] out_total[2];
  logic [3:0] out_count[2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: totals as plain signed integers.
  int m_tot[2];
  int m_ovf[2];
  int m_cnt;
  bit m_done;

  always #5 clk = ~clk;

  // External 4-bit adder for each instance.
  for (genvar k = 0; k < 2; k++) begin : g_add
    assign add_sum[k] = add_a[k] + add_b[k];
    assign add_ovf[k] = (add_a[k][3] == add_b[k][3]) && (add_sum[k][3] != add_a[k][3]);
  end

  acc_sequencer #(.N(N), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]),
    .add_ovf(add_ovf[0]), .flush(flush), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_total(out_total[0]), .out_ovf(out_ovf[0]),
    .out_count(out_count[0]));

  acc_sequencer #(.N(N), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]),
    .add_ovf(add_ovf[1]), .flush(flush), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_total(out_total[1]), .out_ovf(out_ovf[1]),
    .out_count(out_count[1]));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int d, s;
    d = int'($signed(in_data));
    if (rst) begin
      m_tot = '{0, 0}; m_ovf = '{0, 0}; m_cnt = 0; m_done = 0;
    end else if (!m_done) begin
      if (in_valid) begin
        for (int k = 0; k < 2; k++) begin
          s = m_tot[k] + d;
          if (s > 7 || s < -8) begin
            m_ovf[k] = 1;
            if (k == 0) s = (d < 0) ? -8 : 7;
            else        s = (s > 7) ? s - 16 : s + 16;
          end
          m_tot[k] = s;
        end
        m_cnt++;
        if (m_cnt == N || flush) m_done = 1;
      end else if (flush && m_cnt > 0) begin
        m_done = 1;
      end
    end else if (out_ready) begin
      m_tot = '{0, 0}; m_ovf = '{0, 0}; m_cnt = 0; m_done = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_in_ready", k),  {3'b0, in_ready[k]},  {3'b0, !m_done});
      chk($sformatf("d%0d_out_valid", k), {3'b0, out_valid[k]}, {3'b0, m_done});
      chk($sformatf("d%0d_out_total", k), out_total[k], 4'(m_tot[k]));
      chk($sformatf("d%0d_out_ovf", k),   {3'b0, out_ovf[k]},   4'(m_ovf[k]));
      chk($sformatf("d%0d_out_count", k), out_count[k], 4'(m_cnt));
      chk($sformatf("d%0d_add_a", k),     add_a[k], 4'(m_tot[k]));
      chk($sformatf("d%0d_add_b", k),     add_b[k], in_data);
    end
  endtask

  // Apply inputs, clock once, then compare everything 1 time unit later.
  task automatic step(input bit r, input bit v, input int d, input bit f, input bit o);
    rst = r; in_valid = v; in_data = 4'(d); flush = f; out_ready = o;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    m_tot = '{0, 0}; m_ovf = '{0, 0}; m_cnt = 0; m_done = 0;
    step(1, 1, 5, 1, 1);
    step(1, 0, 0, 0, 0);
    chk("rst_out_total", out_total[0], 4'd0);
    chk("rst_in_ready", {3'b0, in_ready[0]}, 4'd1);

    // Four-sample frame with consumer ready throughout.
    step(0, 1, 1, 0, 1);
    step(0, 1, 2, 0, 1);
    step(0, 1, -1, 0, 1);
    step(0, 1, 3, 0, 1);
    chk("f4_out_valid", {3'b0, out_valid[0]}, 4'd1);
    chk("f4_total", out_total[0], 4'd5);
    chk("f4_count", out_count[0], 4'd4);
    chk("f4_ovf", {3'b0, out_ovf[0]}, 4'd0);
    step(0, 0, 0, 0, 1);
    chk("f4_back_acc", {3'b0, in_ready[0]}, 4'd1);

    // Positive overflow then flush: clamp vs wrap.
    step(0, 1, 5, 0, 0);
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("ovf_sat_total", out_total[0], 4'd7);
    chk("ovf_wrap_total", out_total[1], 4'b1011);
    chk("ovf_sat_flag", {3'b0, out_ovf[0]}, 4'd1);
    chk("ovf_wrap_flag", {3'b0, out_ovf[1]}, 4'd1);
    chk("ovf_count", out_count[0], 4'd2);
    step(0, 0, 0, 0, 1);

    // Negative overflow, then walk back off the rail.
    step(0, 1, -6, 0, 0);
    step(0, 1, -5, 0, 0);
    chk("neg_rail", out_total[0], 4'b1000);
    step(0, 1, 4, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("neg_total", out_total[0], 4'hD);
    chk("neg_count", out_count[0], 4'd4);

    // Hold DONE with samples offered; nothing may change.
    for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0);
    chk("hold_total", out_total[0], 4'hD);
    step(0, 1, 3, 0, 1);
    chk("release_count", out_count[0], 4'd0);

    // Flush on an empty frame, then flush together with the first sample.
    step(0, 0, 0, 1, 0);
    chk("flush_empty", {3'b0, out_valid[0]}, 4'd0);
    step(0, 1, 2, 1, 0);
    chk("flush_acc_total", out_total[0], 4'd2);
    chk("flush_acc_count", out_count[0], 4'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Reset mid-frame discards the partial total.
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    chk("mid_total", out_total[0], 4'd3);
    step(1, 1, 4, 1, 1);
    chk("mid_rst_total", out_total[0], 4'd0);
    chk("mid_rst_valid", {3'b0, out_valid[0]}, 4'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter: N, 4, samples per accumulation frame (legal 2..15).
REQ-002 Parameter: SATURATE, 1, 1 = clamp total on signed overflow, 0 = keep wrapped sum.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a sample.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_data  input  4  two's-complement sample.
REQ-008 add_a  output  4  to external 4-bit adder operand A, equals running total.
REQ-009 add_b  output  4  to external adder operand B, equals in_data.
REQ-010 add_sum  input  4  external adder sum, combinational from add_a/add_b, no carry-in.
REQ-011 add_ovf  input  1  external adder signed-overflow flag.
REQ-012 flush  input  1  close current frame early.
REQ-013 out_valid  output  1  frame result available.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 out_total  output  4  frame total, two's complement.
REQ-016 out_ovf  output  1  sticky: any overflow occurred in frame.
REQ-017 out_count  output  4  samples accepted in frame.

Function
REQ-018 Two states: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-019 add_a = total register, add_b = in_data, continuously, in both states.
REQ-020 Accept = in_valid & in_ready; on accept: count += 1, ovf_sticky |= add_ovf.
REQ-021 On accept, no overflow: total <= add_sum.
REQ-022 On accept with add_ovf, SATURATE=1: total <= 4'b0111 if in_data[3]=0, else 4'b1000; SATURATE=0: total <= add_sum.
REQ-023 Accumulation continues from the clamped/wrapped value; later samples may move total away from the rail.
REQ-024 ACC -> DONE on the edge of the accept that makes count = N; out_valid high the following cycle (1-cycle latency).
REQ-025 flush in ACC with accept same cycle: sample included, then -> DONE.
REQ-026 flush in ACC, no accept, count > 0: -> DONE, frame reported with current count.
REQ-027 flush in ACC, no accept, count = 0: ignored, stay ACC.
REQ-028 flush in DONE: ignored.
REQ-029 DONE: out_total, out_ovf, out_count stable while out_valid=1 and out_ready=0.
REQ-030 DONE with out_ready=1: next edge total=0, count=0, ovf_sticky=0, -> ACC; no sample accepted in that cycle even if in_valid=1.
REQ-031 out_total = total, out_ovf = ovf_sticky, out_count = count, driven from registers in both states.
REQ-032 Inputs in_data/in_valid ignored while in_ready=0; no internal buffering.

Reset
REQ-033 rst=1 at an edge: state=ACC, total=0, count=0, ovf_sticky=0; overrides accept/flush/out_ready that same cycle.
REQ-034 Outputs during/after reset: in_ready=1, out_valid=0, out_total=0, out_ovf=0, out_count=0, add_a=0.
REQ-035 Reset mid-frame or in DONE discards the frame; no partial result emitted.

Verification
REQ-036 N=4, samples 1,2,-1,3, out_ready=1 -> out_valid one cycle after 4th accept, out_total=5, out_ovf=0, out_count=4, then ACC.
REQ-037 SATURATE=1, samples 5,6 then flush -> overflow on 2nd, out_total=7, out_ovf=1, out_count=2; SATURATE=0 same -> out_total=-5 (4'b1011), out_ovf=1.
REQ-038 SATURATE=1, samples -6,-5,4,1 -> total -8 after 2nd, out_total=-3, out_ovf=1, out_count=4.
REQ-039 Hold out_ready=0 five cycles in DONE with in_valid=1 -> outputs unchanged, in_ready=0, no count change; release -> clean ACC, count=0.
REQ-040 flush with count=0 -> no DONE; flush with accept of sample 2 as first sample -> out_total=2, out_count=1.
REQ-041 Assert rst after 2 accepts (total=3) -> next cycle total=0, count=0, in_ready=1, out_valid=0.
